// File: rtl/mul_shift_add.sv
// ---------------------------------------------------------------------------
// mul_shift_add
//   Sequential unsigned shift-and-add multiplier. It has the same control
//   interface as the restoring divider, so the two are interchangeable.
//
//   A rising edge on start, seen while idle, latches the operands. The core
//   then consumes one multiplier bit per cycle and reports the 2*WIDTH-bit
//   product with a single-cycle done pulse.
//
//   Optional build macro:
//     MUL_EARLY_EXIT_EN - when the remaining multiplier bits are all zero,
//                         finish CALC in one barrel-shift cycle.
//
// Parameters:
//   WIDTH    operand width, 2..16 (default 4)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   request level; launches on its rising edge
//   operA    in   [WIDTH-1:0]    multiplicand, unsigned
//   operB    in   [WIDTH-1:0]    multiplier, unsigned
//   product  out  [2*WIDTH-1:0]  registered result; held until next completion
//   done     out  one-cycle pulse when product updates
//   busy     out  high from launch through the done cycle
// ---------------------------------------------------------------------------
module mul_shift_add #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     operA,
  input  logic [WIDTH-1:0]     operB,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t             state, state_nxt;
  logic               start_q;
  logic               launch;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH:0]   acc, acc_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;

  // One multiply step. The optional add goes into the upper half, which
  // carries into bit 2W; the shift then brings the next multiplier bit to
  // acc[0].
  function automatic logic [2*WIDTH:0] mul_step(input logic [2*WIDTH:0] a,
                                                input logic [WIDTH-1:0] m);
    logic [2*WIDTH:0] r;
    r = a;
    if (a[0])
      r[2*WIDTH:WIDTH] = {1'b0, a[2*WIDTH-1:WIDTH]} + {1'b0, m};
    return r >> 1;
  endfunction

`ifdef MUL_EARLY_EXIT_EN
  // The unconsumed multiplier bits are the low c bits of acc.
  function automatic logic rem_zero(input logic [WIDTH-1:0] a,
                                    input logic [CW-1:0]    c);
    logic z;
    z = 1'b1;
    for (int i = 0; i < WIDTH; i++)
      if (i < int'(c) && a[i])
        z = 1'b0;
    return z;
  endfunction
`endif

  assign launch = (state == IDLE) && start && !start_q;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (launch) begin
          acc_nxt   = {{(WIDTH+1){1'b0}}, operB};
          cnt_nxt   = CW'(WIDTH);
          state_nxt = CALC;
        end
      end
      CALC: begin
`ifdef MUL_EARLY_EXIT_EN
        if (rem_zero(acc[WIDTH-1:0], cnt)) begin
          // The remaining steps would only shift, so do them all at once.
          acc_nxt   = acc >> cnt;
          cnt_nxt   = '0;
          state_nxt = FIN;
        end else begin
          acc_nxt = mul_step(acc, mcand);
          cnt_nxt = cnt - 1'b1;
          if (cnt == CW'(1))
            state_nxt = FIN;
        end
`else
        acc_nxt = mul_step(acc, mcand);
        cnt_nxt = cnt - 1'b1;
        if (cnt == CW'(1))
          state_nxt = FIN;
`endif
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      start_q <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      product <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      cnt     <= cnt_nxt;
      done    <= (state == FIN);
      if (state == FIN)
        product <= acc[2*WIDTH-1:0];
      // A relaunch on the edge that ends the done cycle keeps busy high.
      if (launch)
        busy <= 1'b1;
      else if (done)
        busy <= 1'b0;
    end
  end

  // datapath registers
  always_ff @(posedge clk) begin
    acc <= acc_nxt;
    if (launch)
      mcand <= operA;
  end

endmodule

// File: tb/tb_mul_shift_add.sv
module tb_mul_shift_add;

  localparam int WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [WIDTH-1:0]     operA = '0;
  logic [WIDTH-1:0]     operB = '0;
  logic [2*WIDTH-1:0]   product;
  logic                 done;
  logic                 busy;

  int checks   = 0;
  int failures = 0;

  mul_shift_add #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .operA   (operA),
    .operB   (operB),
    .product (product),
    .done    (done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

`ifdef MUL_EARLY_EXIT_EN
  localparam int LAT_4X2  = 4;
  localparam int LAT_3X5  = 5;
  localparam int LAT_9X0  = 2;
  localparam int LAT_2X3  = 4;
`else
  localparam int LAT_4X2  = 5;
  localparam int LAT_3X5  = 5;
  localparam int LAT_9X0  = 5;
  localparam int LAT_2X3  = 5;
`endif
  localparam int LAT_FULL = 5;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise start, wait for done, and check product, latency and busy. start
  // is left high. When chg_at is nonzero, operA is set to chg_val right
  // after edge E<chg_at>.
  task automatic do_op(input string tag, input int a, input int b,
                       input int exp_p, input int exp_lat,
                       input int chg_at, input int chg_val);
    int n;
    int busy_low;
    int held;
    operA = WIDTH'(a);
    operB = WIDTH'(b);
    start = 1'b1;
    tick();                       // E0
    n = 0;
    busy_low = 0;
    while (n < 20) begin
      if (!busy) busy_low++;
      tick();
      n++;
      if (chg_at != 0 && n == chg_at) operA = WIDTH'(chg_val);
      if (done) break;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_product"}, int'(product), exp_p);
    chk({tag, "_busy_in_flight_low"}, busy_low, 0);
    chk({tag, "_busy_done_cycle"}, int'(busy), 1);
    held = int'(product);
    tick();
    chk({tag, "_done_pulse_end"}, int'(done), 0);
    chk({tag, "_busy_end"}, int'(busy), 0);
    chk({tag, "_product_hold"}, int'(product), held);
  endtask

  initial begin
    int extra_done;

    // Reset held 2 cycles.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_product", int'(product), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    tick();
    tick();

    // 4 x 2 with start held 10 cycles: no retrigger.
    do_op("mul4x2", 4, 2, 8, LAT_4X2, 0, 0);
    extra_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) extra_done++;
      tick();
    end
    chk("mul4x2_no_retrigger", extra_done, 0);
    start = 1'b0;
    tick();
    tick();

    // 3 x 5 with operA changed at E2.
    do_op("mul3x5", 3, 5, 15, LAT_3X5, 2, 9);
    start = 1'b0;
    tick();
    tick();

    // Largest operands.
    do_op("mul15x15", 15, 15, 225, LAT_FULL, 0, 0);
    start = 1'b0;
    tick();
    tick();

    // Zero multiplier.
    do_op("mul9x0", 9, 0, 0, LAT_9X0, 0, 0);
    start = 1'b0;
    tick();
    tick();

    // Reset mid-operation: 7 x 6, rst sampled at E2.
    operA = 4'd7;
    operB = 4'd6;
    start = 1'b1;
    tick();                       // E0
    tick();                       // E1
    rst   = 1'b1;
    start = 1'b0;
    tick();                       // E2
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_product", int'(product), 0);
    chk("abort_done", int'(done), 0);
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) extra_done++;
      tick();
    end
    chk("abort_no_done", extra_done, 0);
    do_op("mul7x6", 7, 6, 42, LAT_FULL, 0, 0);
    start = 1'b0;
    tick();
    tick();

    // start high through reset counts as a rising edge after release.
    operA = 4'd2;
    operB = 4'd3;
    rst   = 1'b1;
    start = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    do_op("rst_start", 2, 3, 6, LAT_2X3, 0, 0);
    start = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
